// File: rtl/prog_seq_pkg.sv
// Shared types for the front-panel program sequencer: FSM states, control codes
// and the 14-bit program word layout {ctl, opcode, operand}.
package prog_seq_pkg;

  localparam int CTL_W    = 2;
  localparam int OPC_W    = 4;
  localparam int OPND_W   = 8;
  localparam int WORD_W   = CTL_W + OPC_W + OPND_W;
  localparam int ISSUED_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SETUP,
    ST_PRESS,
    ST_RELEASE,
    ST_DONE
  } state_t;

  typedef enum logic [CTL_W-1:0] {
    CTL_ISSUE = 2'b00,
    CTL_HALT  = 2'b01,
    CTL_SKIPZ = 2'b10,
    CTL_SKIPC = 2'b11
  } ctl_t;

  typedef struct packed {
    ctl_t               ctl;
    logic [OPC_W-1:0]   opcode;
    logic [OPND_W-1:0]  operand;
  } word_t;

endpackage

// File: rtl/prog_seq_mem.sv
// Program store: PROG_DEPTH words, synchronous write, asynchronous read.
// Contents survive reset on purpose so a program can be replayed after one.
module prog_seq_mem
  import prog_seq_pkg::*;
#(
  parameter int PROG_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          we,
  input  logic [$clog2(PROG_DEPTH)-1:0] waddr,
  input  word_t                         wdata,
  input  logic [$clog2(PROG_DEPTH)-1:0] raddr,
  output word_t                         rdata
);

  word_t mem [PROG_DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/program_sequencer.sv
// Replays a stored opcode/operand program onto the datapath front panel as timed
// key_0 strokes. Define PROG_SEQ_SKIP_EN to enable the SKIPZ/SKIPC flag skips.
module program_sequencer
  import prog_seq_pkg::*;
#(
  parameter int PROG_DEPTH     = 16,
  parameter int SETUP_CYCLES   = 1,
  parameter int PRESS_CYCLES   = 2,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          prog_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
  input  logic [WORD_W-1:0]             prog_data,
  input  logic                          start,
  input  logic                          cFlag,
  input  logic                          zFlag,
  output logic                          key_0,
  output logic [OPC_W-1:0]              opcode,
  output logic [OPND_W-1:0]             switchInput,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(PROG_DEPTH)-1:0] pc,
  output logic [ISSUED_W-1:0]           issued
);

  localparam int AW    = $clog2(PROG_DEPTH);
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRESS_LAST   = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);

  state_t           state, state_next;
  word_t            word;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]    pc_next;
  logic [AW:0]      skip_target;
  logic             is_skip;
  logic             skip_flag;

  function automatic logic [ISSUED_W-1:0] sat_inc(input logic [ISSUED_W-1:0] v);
    return (v == '1) ? v : v + ISSUED_W'(1);
  endfunction

  prog_seq_mem #(.PROG_DEPTH(PROG_DEPTH)) u_mem (
    .clock (clock),
    .we    (prog_we && !busy),
    .waddr (prog_addr),
    .wdata (word_t'(prog_data)),
    .raddr (pc),
    .rdata (word)
  );

`ifdef PROG_SEQ_SKIP_EN
  assign is_skip   = word.ctl inside {CTL_SKIPZ, CTL_SKIPC};
  assign skip_flag = (word.ctl == CTL_SKIPZ) ? zFlag : cFlag;
`else
  // Skip codes fall through to ISSUE, so the flags have no reader.
  logic unused_flags;
  assign unused_flags = cFlag ^ zFlag;
  assign is_skip      = 1'b0;
  assign skip_flag    = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    skip_target = {1'b0, pc} + (skip_flag ? (AW+1)'(2) : (AW+1)'(1));
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next = ST_FETCH;
          pc_next    = '0;
        end
      end
      ST_FETCH: begin
        if (word.ctl == CTL_HALT) begin
          state_next = ST_DONE;
        end else if (is_skip) begin
          // A skip past the last word ends the program rather than wrapping.
          if (skip_target >= (AW+1)'(PROG_DEPTH)) begin
            state_next = ST_DONE;
          end else begin
            pc_next = skip_target[AW-1:0];
          end
        end else begin
          state_next = ST_SETUP;
        end
      end
      ST_SETUP:   if (cnt == SETUP_LAST) state_next = ST_PRESS;
      ST_PRESS:   if (cnt == PRESS_LAST) state_next = ST_RELEASE;
      ST_RELEASE: begin
        if (cnt == RELEASE_LAST) begin
          if (pc == AW'(PROG_DEPTH - 1)) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_FETCH;
            pc_next    = pc + AW'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    key_0 = (state != ST_PRESS);
    busy  = (state != ST_IDLE) && (state != ST_DONE);
    done  = (state == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= '0;
      cnt         <= '0;
      opcode      <= '0;
      switchInput <= '0;
      issued      <= '0;
    end else begin
      pc  <= pc_next;
      cnt <= (state_next != state) ? '0 : cnt + CNT_W'(1);
      // Operands latch only when a stroke begins, so they hold through release.
      if (state == ST_FETCH && state_next == ST_SETUP) begin
        opcode      <= word.opcode;
        switchInput <= word.operand;
      end
      if (state == ST_PRESS && state_next == ST_RELEASE) begin
        issued <= sat_inc(issued);
      end
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: a program-level interpreter predicts every output
// cycle; directed scenarios plus randomized programs and busy-time pokes.
module tb_program_sequencer;
  import prog_seq_pkg::*;

  localparam int DEPTH = 16;
  localparam int SETUP = 1;
  localparam int PRESS = 2;
  localparam int REL   = 2;
  localparam int AW    = $clog2(DEPTH);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          prog_we = 1'b0;
  logic          start = 1'b0;
  logic          cFlag = 1'b0;
  logic          zFlag = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [13:0]   prog_data = '0;
  logic          key_0;
  logic [3:0]    opcode;
  logic [7:0]    switchInput;
  logic          busy;
  logic          done;
  logic [AW-1:0] pc;
  logic [7:0]    issued;

  program_sequencer #(
    .PROG_DEPTH(DEPTH), .SETUP_CYCLES(SETUP), .PRESS_CYCLES(PRESS), .RELEASE_CYCLES(REL)
  ) dut (
    .clock(clock), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .cFlag(cFlag), .zFlag(zFlag),
    .key_0(key_0), .opcode(opcode), .switchInput(switchInput), .busy(busy),
    .done(done), .pc(pc), .issued(issued)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic          key;
    logic [3:0]    opc;
    logic [7:0]    sw;
    logic          busy;
    logic          done;
    logic [AW-1:0] pc;
    logic [7:0]    iss;
  } snap_t;

  snap_t       cur;
  snap_t       timeline[$];
  logic [13:0] mem_m [DEPTH];
  int          checks = 0;
  int          errors = 0;
  bit          check_en = 1'b0;
  int          step_no = 0;
  int          fall_step = 0;
  int          busy_total = 0;
  int          low_total = 0;

  function automatic snap_t mk(logic k, logic [3:0] o, logic [7:0] s, logic b, logic d,
                               logic [AW-1:0] p, logic [7:0] i);
    snap_t r;
    r.key = k; r.opc = o; r.sw = s; r.busy = b; r.done = d; r.pc = p; r.iss = i;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Interpret the stored program word by word and lay out the expected cycles.
  task automatic build();
    int          p = 0;
    logic [7:0]  iss = cur.iss;
    logic [3:0]  o = cur.opc;
    logic [7:0]  s = cur.sw;
    logic [13:0] w;
    timeline.delete();
    forever begin
      w = mem_m[p];
      timeline.push_back(mk(1'b1, o, s, 1'b1, 1'b0, AW'(p), iss));
      if (w[13:12] == 2'b01) break;
`ifdef PROG_SEQ_SKIP_EN
      if (w[13]) begin
        int t = p + ((((w[12] == 1'b0) ? zFlag : cFlag) == 1'b1) ? 2 : 1);
        if (t >= DEPTH) break;
        p = t;
        continue;
      end
`endif
      o = w[11:8];
      s = w[7:0];
      repeat (SETUP) timeline.push_back(mk(1'b1, o, s, 1'b1, 1'b0, AW'(p), iss));
      repeat (PRESS) timeline.push_back(mk(1'b0, o, s, 1'b1, 1'b0, AW'(p), iss));
      if (iss != 8'd255) iss = iss + 8'd1;
      repeat (REL) timeline.push_back(mk(1'b1, o, s, 1'b1, 1'b0, AW'(p), iss));
      if (p == DEPTH - 1) break;
      p++;
    end
    timeline.push_back(mk(1'b1, o, s, 1'b0, 1'b1, AW'(p), iss));
  endtask

  // Advance one clock; the model applies whatever the inputs were at that edge.
  task automatic step();
    bit was_busy;
    @(posedge clock);
    was_busy = cur.busy;
    if (reset) begin
      cur = mk(1'b1, 4'h0, 8'h00, 1'b0, 1'b0, '0, 8'h00);
      timeline.delete();
    end else begin
      if (prog_we && !was_busy) mem_m[prog_addr] = prog_data;
      if (start && !was_busy) build();
      if (timeline.size() > 0) cur = timeline.pop_front();
    end
    step_no++;
    #1;
  endtask

  task automatic write_word(input int a, input logic [13:0] d);
    prog_we = 1'b1; prog_addr = AW'(a); prog_data = d;
    step();
    prog_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_out();
    repeat (timeline.size() + 2) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  function automatic logic [13:0] rand_word();
    int r = $urandom_range(0, 9);
    logic [1:0] c = (r < 6) ? 2'b00 : (r < 7) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11;
    return {c, 4'($urandom), 8'($urandom)};
  endfunction

  initial begin
    logic prev_key;
    prev_key = 1'b1;
    forever begin
      @(negedge clock);
      if (check_en) begin
        chk("key_0", key_0, cur.key);
        chk("opcode", opcode, cur.opc);
        chk("switchInput", switchInput, cur.sw);
        chk("busy", busy, cur.busy);
        chk("done", done, cur.done);
        chk("pc", pc, cur.pc);
        chk("issued", issued, cur.iss);
        if (busy === 1'b1) busy_total++;
        if (key_0 === 1'b0) low_total++;
        if (key_0 === 1'b0 && prev_key === 1'b1) fall_step = step_no;
        prev_key = key_0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int b0;
    int l0;
    int s0;
    cur = mk(1'b1, 4'h0, 8'h00, 1'b0, 1'b0, '0, 8'h00);
    step();
    check_en = 1'b1;
    step();
    chk("rst_key_0", key_0, 1);
    chk("rst_busy", busy, 0);
    chk("rst_issued", issued, 0);
    reset = 1'b0;
    for (int a = 0; a < DEPTH; a++) write_word(a, 14'h1000);

    // One stroke then HALT
    write_word(0, {2'b00, 4'h1, 8'h36});
    b0 = busy_total; l0 = low_total;
    do_start();
    s0 = step_no;
    run_out();
    chk("t1_busy_cycles", busy_total - b0, 7);
    chk("t1_low_cycles", low_total - l0, 2);
    chk("t1_fall_delay", fall_step - s0, 2);
    chk("t1_opcode", opcode, 4'h1);
    chk("t1_switch", switchInput, 8'h36);
    chk("t1_issued", issued, 1);
    chk("t1_done", done, 1);

    // Restart from DONE
    do_start();
    chk("rs_done_clear", done, 0);
    chk("rs_busy", busy, 1);
    chk("rs_pc", pc, 0);
    run_out();
    chk("rs_issued", issued, 2);

    // Full program with no HALT: runs off the end into DONE
    for (int a = 0; a < DEPTH; a++) write_word(a, {2'b00, a[0] ? 4'h2 : 4'h1, 8'($urandom)});
    l0 = low_total;
    do_start();
    run_out();
    chk("t2_low_cycles", low_total - l0, 32);
    chk("t2_pc", pc, 15);
    chk("t2_done", done, 1);
    chk("t2_issued", issued, 18);

    // Writes and start while busy are ignored
    do_start();
    repeat (5) step();
    prog_we = 1'b1; prog_addr = '0; prog_data = 14'h1000; start = 1'b1;
    step();
    prog_we = 1'b0; start = 1'b0;
    repeat (8) step();
    do_start();
    run_out();
    chk("bi_issued", issued, 34);
    chk("bi_pc", pc, 15);

    // Reset in the middle of a press
    do_start();
    for (int n = 0; n < 20 && cur.key !== 1'b0; n++) step();
    chk("rp_in_press", key_0, 0);
    do_reset();
    chk("rp_key_0", key_0, 1);
    chk("rp_opcode", opcode, 0);
    chk("rp_switch", switchInput, 0);
    chk("rp_busy", busy, 0);
    chk("rp_done", done, 0);
    chk("rp_pc", pc, 0);
    chk("rp_issued", issued, 0);
    do_start();
    run_out();
    chk("rp_replay_issued", issued, 16);

    // Saturation of the stroke counter
    for (int r = 0; r < 16; r++) begin
      do_start();
      run_out();
    end
    chk("sat_issued", issued, 255);

    // Conditional skip program
    write_word(0, {2'b00, 4'h1, 8'h05});
    write_word(1, {2'b10, 4'h0, 8'h00});
    write_word(2, {2'b00, 4'h2, 8'h11});
    write_word(3, {2'b00, 4'h3, 8'h22});
    write_word(4, 14'h1000);
    zFlag = 1'b1;
    do_reset();
    do_start();
    run_out();
`ifdef PROG_SEQ_SKIP_EN
    chk("sk_z1_issued", issued, 2);
`else
    chk("sk_z1_issued", issued, 4);
`endif
    chk("sk_z1_switch", switchInput, 8'h22);
    zFlag = 1'b0;
    do_reset();
    do_start();
    run_out();
`ifdef PROG_SEQ_SKIP_EN
    chk("sk_z0_issued", issued, 3);
`else
    chk("sk_z0_issued", issued, 4);
`endif

    // Randomized programs, flags and pokes while running
    for (int it = 0; it < 10; it++) begin
      cFlag = 1'($urandom); zFlag = 1'($urandom);
      for (int a = 1; a < DEPTH; a++) write_word(a, rand_word());
      prog_we = 1'b1; prog_addr = '0; prog_data = rand_word(); start = 1'b1;
      step();
      for (int n = 0; n < 200 && timeline.size() > 0; n++) begin
        start     = ($urandom_range(0, 3) == 0);
        prog_we   = ($urandom_range(0, 3) == 0);
        prog_addr = AW'($urandom);
        prog_data = rand_word();
        reset     = ($urandom_range(0, 59) == 0);
        step();
      end
      start = 1'b0; prog_we = 1'b0; reset = 1'b0;
      step();
    end

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
